// File: rtl/pc_seq_ctrl_pkg.sv
// Shared definitions for the fetch-stage sequencer: state encoding, default
// reset/exception addresses, legal fetch window and the AdEL exception code.
package pc_seq_ctrl_pkg;

    localparam int unsigned WIDTH_IFSTATE = 2;

    typedef enum logic [WIDTH_IFSTATE-1:0] {
        StFetch = 2'd0,
        StHold  = 2'd1,
        StDrain = 2'd2
    } if_state_e;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] DEF_IMEM_LO    = 32'h0000_3000;
    localparam logic [31:0] DEF_IMEM_HI    = 32'h0000_6FFC;

    // ExcCode for an address error on load/fetch, applied downstream
    localparam logic [4:0] EXC_ADEL = 5'd4;

endpackage

// File: rtl/pc_seq_ctrl_adel_chk.sv
// pc_adel_chk: combinational alignment/range check on a fetch address.
// Only instantiated when IF_ADEL_CHECK_EN is defined.
module pc_adel_chk
    import pc_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] IMEM_LO = DEF_IMEM_LO,
    parameter logic [31:0] IMEM_HI = DEF_IMEM_HI
) (
    input  logic [31:0] pc,
    output logic        adel
);

    // Misaligned or outside the instruction memory window
    always_comb begin
        adel = (pc[1:0] != 2'b00) || (pc < IMEM_LO) || (pc > IMEM_HI);
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: fetch-stage sequencer owning the PC. Handshakes with a
// multi-cycle instruction memory, buffers one word toward ID and keeps the
// branch-delay slot ahead of any redirect target.
// Optional fetch address-error check: define IF_ADEL_CHECK_EN.
module pc_seq_ctrl
    import pc_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
`ifdef IF_ADEL_CHECK_EN
    ,
    parameter logic [31:0] IMEM_LO    = DEF_IMEM_LO,
    parameter logic [31:0] IMEM_HI    = DEF_IMEM_HI
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_bd,
    output logic        if_exc
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        if_exc_q, if_exc_d;

    logic        adel;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fetch_done;
    logic        handoff;

`ifdef IF_ADEL_CHECK_EN
    pc_adel_chk #(
        .IMEM_LO (IMEM_LO),
        .IMEM_HI (IMEM_HI)
    ) u_adel_chk (
        .pc   (pc_q),
        .adel (adel)
    );
`else
    assign adel = 1'b0;
`endif

    // Flush and hand-off qualifiers; exc beats eret, any flush beats hand-off
    always_comb begin
        flush      = exc_req | eret_req;
        flush_pc   = exc_req ? EXC_VECTOR : epc;
        // A bad address completes the fetch without ever reaching memory
        fetch_done = (state_q == StFetch) & (imem_ready | adel);
        handoff    = (state_q == StHold) & if_ready & ~flush;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (flush) begin
                    // Outstanding request must be drained before retargeting
                    state_d = fetch_done ? StFetch : StDrain;
                end else if (fetch_done) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (flush || if_ready) begin
                    state_d = StFetch;
                end
            end
            StDrain: begin
                if (imem_ready) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req  = ~reset & (((state_q == StFetch) & ~adel) | (state_q == StDrain));
        imem_addr = (state_q == StDrain) ? drain_addr_q : {pc_q[31:2], 2'b00};
        if_valid  = ~reset & (state_q == StHold);
        if_bd     = (state_q == StHold) & (pend_vld_q | redirect_valid);
        if_instr  = if_instr_q;
        if_pc     = if_pc_q;
        if_exc    = if_exc_q;
    end

    // PC selection, pending redirect and fetch buffer next values
    always_comb begin
        pc_d         = pc_q;
        pend_vld_d   = pend_vld_q;
        pend_pc_d    = pend_pc_q;
        drain_addr_d = drain_addr_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        if_exc_d     = if_exc_q;

        if (flush) begin
            pc_d       = flush_pc;
            pend_vld_d = 1'b0;
            if ((state_q == StFetch) && !fetch_done) begin
                drain_addr_d = {pc_q[31:2], 2'b00};
            end
        end else if (handoff) begin
            pend_vld_d = 1'b0;
            if (redirect_valid) begin
                pc_d = redirect_pc;
            end else if (pend_vld_q) begin
                pc_d = pend_pc_q;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end else if (redirect_valid) begin
            // Word in flight or held is the delay slot; remember the target
            pend_vld_d = 1'b1;
            pend_pc_d  = redirect_pc;
        end

        if (!flush && fetch_done) begin
            if_instr_d = adel ? 32'h0 : imem_rdata;
            if_pc_d    = pc_q;
            if_exc_d   = adel;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            pend_vld_q   <= 1'b0;
            pend_pc_q    <= 32'h0;
            drain_addr_q <= 32'h0;
            if_instr_q   <= 32'h0;
            if_pc_q      <= RESET_PC;
            if_exc_q     <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pend_vld_q   <= pend_vld_d;
            pend_pc_q    <= pend_pc_d;
            drain_addr_q <= drain_addr_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            if_exc_q     <= if_exc_d;
        end
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: memory model with programmable latency, scoreboard
// queues for expected request addresses and expected ID hand-offs.
module tb_pc_seq_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic        bd;
    } hand_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        exc_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_bd;
    logic        if_exc;

    int n_checks = 0;
    int n_errs   = 0;
    int lat      = 2;
    int cnt      = 0;
    logic        prev_req  = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    logic [31:0] exp_req[$];
    hand_t       exp_hand[$];

    pc_seq_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .exc_req        (exc_req),
        .eret_req       (eret_req),
        .epc            (epc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_bd          (if_bd),
        .if_exc         (if_exc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0F00;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic [31:0] a);
        int n = 0;
        while (!(imem_req && imem_addr == a) && n < 200) begin
            step();
            n++;
        end
        check_eq("wait_req_vld", imem_req, 1'b1);
        check_eq("wait_req_addr", imem_addr, a);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!if_valid && n < 200) begin
            step();
            n++;
        end
        check_eq("wait_valid", if_valid, 1'b1);
    endtask

    // Monitor (request + hand-off scoreboard) followed by the memory model
    always @(negedge clk) begin : mon
        logic  start;
        hand_t h;
        if (reset) begin
            check_eq("rst_if_valid", if_valid, 1'b0);
            check_eq("rst_imem_req", imem_req, 1'b0);
            cnt        = 0;
            imem_ready = 1'b0;
            prev_req   = 1'b0;
        end else begin
            start = imem_req && (!prev_req || imem_addr != prev_addr || imem_ready);
            if (start) begin
                if (exp_req.size() > 0) check_eq("req_addr", imem_addr, exp_req.pop_front());
                else check_eq("req_extra", exp_req.size(), 1);
            end
            if (if_valid && if_ready) begin
                if (exp_hand.size() > 0) begin
                    h = exp_hand.pop_front();
                    check_eq("hand_pc", if_pc, h.pc);
                    check_eq("hand_instr", if_instr, mem_word(h.pc));
                    check_eq("hand_bd", if_bd, h.bd);
                    check_eq("hand_exc", if_exc, 1'b0);
                end else begin
                    check_eq("hand_extra", exp_hand.size(), 1);
                end
            end
            if (!imem_req) begin
                cnt        = 0;
                imem_ready = 1'b0;
            end else begin
                cnt        = start ? 1 : cnt + 1;
                imem_ready = (cnt >= lat);
                imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;
            end
            prev_req  = imem_req;
            prev_addr = imem_addr;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held_instr;
        logic [31:0] held_pc;
        logic [31:0] reqs[15] = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010, 32'h3014,
                                  32'h3100, 32'h3104, 32'h3108, 32'h3020, 32'h4180, 32'h4184,
                                  32'h4180, 32'h3040, 32'h3200};
        logic [31:0] hpc[10] = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010, 32'h3014,
                                 32'h3100, 32'h3104, 32'h3108, 32'h4180};
        logic        hbd[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
        for (int i = 0; i < 15; i++) exp_req.push_back(reqs[i]);
        for (int i = 0; i < 10; i++) exp_hand.push_back('{pc: hpc[i], bd: hbd[i]});

        repeat (3) step();
        check_eq("rst_if_pc", if_pc, 32'h3000);
        check_eq("rst_if_instr", if_instr, 32'h0);
        check_eq("rst_if_bd", if_bd, 1'b0);
        check_eq("rst_if_exc", if_exc, 1'b0);
        reset = 1'b0;

        // Branch at 0x3010 resolved while 0x3014 (delay slot) is in flight
        wait_req(32'h3014);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3100;
        step();
        redirect_valid = 1'b0;

        // ID stall while 0x3104 is held
        wait_req(32'h3104);
        if_ready = 1'b0;
        wait_valid();
        held_instr = if_instr;
        held_pc    = if_pc;
        check_eq("stall_pc", held_pc, 32'h3104);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("stall_instr", if_instr, held_instr);
            check_eq("stall_pc_hold", if_pc, held_pc);
            check_eq("stall_no_req", imem_req, 1'b0);
        end
        if_ready = 1'b1;

        // Jump to 0x3020 with 0x3108 as delay slot; slower memory from here on
        wait_req(32'h3108);
        lat            = 3;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3020;
        step();
        redirect_valid = 1'b0;

        // Exception while 0x3020 is pending: drained, then vector
        wait_req(32'h3020);
        exc_req = 1'b1;
        step();
        exc_req = 1'b0;
        for (int n = 0; n < 50 && !(imem_req && imem_addr == 32'h4180); n++) begin
            check_eq("drain_if_valid", if_valid, 1'b0);
            step();
        end
        check_eq("exc_vector_req", imem_addr, 32'h4180);

        // exc and eret together: exc wins
        wait_req(32'h4184);
        exc_req  = 1'b1;
        eret_req = 1'b1;
        epc      = 32'h3040;
        step();
        exc_req  = 1'b0;
        eret_req = 1'b0;

        // eret alone returns to epc
        wait_req(32'h4180);
        if_ready = 1'b0;
        eret_req = 1'b1;
        step();
        eret_req = 1'b0;

        // Flush while holding: held word dropped, refetch at new epc
        wait_req(32'h3040);
        wait_valid();
        check_eq("eret_pc", if_pc, 32'h3040);
        check_eq("eret_bd", if_bd, 1'b0);
        eret_req = 1'b1;
        epc      = 32'h3200;
        step();
        eret_req = 1'b0;
        check_eq("hold_flush_valid", if_valid, 1'b0);
        check_eq("hold_flush_req", imem_req, 1'b1);
        check_eq("hold_flush_addr", imem_addr, 32'h3200);
        wait_valid();
        check_eq("refetch_pc", if_pc, 32'h3200);
        check_eq("refetch_instr", if_instr, mem_word(32'h3200));

`ifdef IF_ADEL_CHECK_EN
        // Redirect to a misaligned target: no request, error word presented
        exp_hand.push_back('{pc: 32'h3200, bd: 1'b1});
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3002;
        if_ready       = 1'b1;
        step();
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        check_eq("adel_no_req", imem_req, 1'b0);
        step();
        check_eq("adel_valid", if_valid, 1'b1);
        check_eq("adel_exc", if_exc, 1'b1);
        check_eq("adel_instr", if_instr, 32'h0);
        check_eq("adel_pc", if_pc, 32'h3002);
`endif

        repeat (3) step();
        check_eq("req_left", exp_req.size(), 0);
        check_eq("hand_left", exp_hand.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
